// File: rtl/mpe_column_sequencer_if.sv
// Control/status bundle between the layer controller, the column sequencer and the MPE column.
// master = controller side, slave = sequencer side.
interface mpe_column_sequencer_if #(
  parameter int NUMBER_PE = 9,
  parameter int WIN_W     = 16
);
  logic                 i_start;
  logic                 i_reuse_w;
  logic [WIN_W-1:0]     i_num_win;
  logic                 i_abort;
  logic                 weight_en;
  logic [NUMBER_PE-1:0] o_left_en;
  logic [NUMBER_PE-1:0] o_right_en;
  logic [NUMBER_PE-1:0] o_fmap_rd;
  logic                 o_psum_valid;
  logic [WIN_W-1:0]     o_psum_idx;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_start, i_reuse_w, i_num_win, i_abort,
    input  weight_en, o_left_en, o_right_en, o_fmap_rd,
           o_psum_valid, o_psum_idx, o_busy, o_done
  );

  modport slave (
    input  i_start, i_reuse_w, i_num_win, i_abort,
    output weight_en, o_left_en, o_right_en, o_fmap_rd,
           o_psum_valid, o_psum_idx, o_busy, o_done
  );
endinterface

// File: rtl/mpe_column_sequencer.sv
// Job sequencer for one NUMBER_PE x 1 MPE column: weight load, skewed enable ramp,
// streaming and psum drain. Every output is registered from the next-state values.
module mpe_column_sequencer #(
  parameter int NUMBER_PE = 9,
  parameter int PSUM_LAT  = 12,
  parameter int WIN_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rest_n,
  mpe_column_sequencer_if.slave  bus
);
  localparam int TW = WIN_W + 8;
  localparam logic [TW-1:0] PSUM_BASE = TW'(NUMBER_PE - 1 + PSUM_LAT);
  localparam logic [TW-1:0] T_OFS     = TW'(NUMBER_PE + PSUM_LAT - 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state, nxt_state;
  logic [TW-1:0]        t, nxt_t, t_end, n_ext;
  logic [WIN_W-1:0]     n_q, nxt_n;
  logic [NUMBER_PE-1:0] nxt_en, en_q;
  logic                 nxt_pv, pv_q, we_q, busy_q, done_q;
  logic [WIN_W-1:0]     nxt_idx, idx_q;

  assign t_end = {8'b0, n_q} + T_OFS;
  assign n_ext = {8'b0, nxt_n};

  always_comb begin
    nxt_state = state;
    nxt_t     = t;
    nxt_n     = n_q;
    unique case (state)
      IDLE: begin
        // abort outranks a coincident start
        if (bus.i_start && !bus.i_abort) begin
          nxt_n = bus.i_num_win;
          nxt_t = '0;
          if (bus.i_num_win == '0) nxt_state = DONE;
          else if (bus.i_reuse_w)  nxt_state = RUN;
          else                     nxt_state = LOAD;
        end
      end
      LOAD: begin
        nxt_t     = '0;
        nxt_state = bus.i_abort ? IDLE : RUN;
      end
      RUN: begin
        if (bus.i_abort) begin
          nxt_state = IDLE;
          nxt_t     = '0;
        end else if (t == t_end) begin
          nxt_state = DONE;
          nxt_t     = '0;
        end else begin
          nxt_t = t + 1'b1;
        end
      end
      DONE: nxt_state = IDLE;
    endcase
  end

  // Diagonal wavefront: PE k sees windows 0..N-1 at t = k..k+N-1
  for (genvar k = 0; k < NUMBER_PE; k++) begin : g_lane
    assign nxt_en[k] = (nxt_state == RUN) && (nxt_t >= TW'(k)) && (nxt_t < TW'(k) + n_ext);
  end

  assign nxt_pv  = (nxt_state == RUN) && (nxt_t >= PSUM_BASE) && (nxt_t < n_ext + PSUM_BASE);
  assign nxt_idx = nxt_pv ? WIN_W'(nxt_t - PSUM_BASE) : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rest_n) begin
      state  <= IDLE;
      t      <= '0;
      n_q    <= '0;
      en_q   <= '0;
      pv_q   <= 1'b0;
      idx_q  <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      t      <= nxt_t;
      n_q    <= nxt_n;
      en_q   <= nxt_en;
      pv_q   <= nxt_pv;
      idx_q  <= nxt_idx;
      we_q   <= (nxt_state == LOAD);
      busy_q <= (nxt_state != IDLE);
      done_q <= (nxt_state == DONE);
    end
  end

  assign bus.weight_en    = we_q;
  assign bus.o_left_en    = en_q;
  assign bus.o_right_en   = en_q;
  assign bus.o_fmap_rd    = en_q;
  assign bus.o_psum_valid = pv_q;
  assign bus.o_psum_idx   = idx_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
endmodule
